// File: rtl/prim_fifo_downsizer.sv
// Width down-converter: pops one InWidth word and emits Ratio narrow beats with a last marker.
// Optional macro PRIM_FIFO_DOWNSIZER_MSB_FIRST_EN emits the most-significant slice first.
module prim_fifo_downsizer #(
    parameter int InWidth  = 32,
    parameter int OutWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [InWidth-1:0]  in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_last_o,
    input  logic                flush_i,
    output logic                busy_o
);

    localparam int Ratio = InWidth / OutWidth;
    localparam int CntW  = $clog2(Ratio);

    if ((InWidth % OutWidth) != 0 || Ratio < 2) begin : g_param_check
        $error("prim_fifo_downsizer: InWidth must be a multiple of OutWidth with ratio >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [InWidth-1:0]   word_q, word_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    logic [Ratio-1:0][OutWidth-1:0] slices;
    logic [CntW-1:0]                beat_idx;
    logic                           cnt_at_last;

    assign slices      = word_q;
    assign cnt_at_last = (cnt_q == CntW'(Ratio - 1));

`ifdef PRIM_FIFO_DOWNSIZER_MSB_FIRST_EN
    assign beat_idx = CntW'(Ratio - 1) - cnt_q;
`else
    assign beat_idx = cnt_q;
`endif

    // All beat-side outputs decode from registers only.
    assign out_valid_o = (state_q == SEND);
    assign busy_o      = out_valid_o;
    assign out_data_o  = slices[beat_idx];
    assign out_last_o  = out_valid_o && cnt_at_last;

    // Ready depends on out_ready_i but never on in_valid_i.
    assign in_ready_o = !rst_i && !flush_i &&
                        ((state_q == IDLE) || (out_ready_i && out_last_o));

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        word_d  = in_data_i;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_ready_i) begin
                        if (!cnt_at_last) begin
                            cnt_d = cnt_q + CntW'(1);
                        end else if (in_valid_i) begin
                            // Reload on the last beat for bubble-free back-to-back words.
                            word_d = in_data_i;
                            cnt_d  = '0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_prim_fifo_downsizer.sv
// Bench for prim_fifo_downsizer: queue-of-beats reference model, directed and random scenarios.
module tb_prim_fifo_downsizer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_last;
    logic          flush = 1'b0;
    logic          busy;

    int checks = 0;
    int failures = 0;

    // Pending beats of the word currently held, front = beat on the bus.
    logic [OW-1:0] exp_q[$];

    logic [OW+3:0] obs_v;
    assign obs_v = {out_valid, out_last, busy, in_ready, (out_valid ? out_data : {OW{1'b0}})};

    always #5 clk = ~clk;

    prim_fifo_downsizer #(.InWidth(IW), .OutWidth(OW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_last_o(out_last), .flush_i(flush), .busy_o(busy)
    );

    function automatic logic [OW+3:0] model_exp();
        logic v, last, rdy;
        v    = (exp_q.size() != 0);
        last = (exp_q.size() == 1);
        rdy  = !rst && !flush && (!v || (out_ready && last));
        return {v, last, v, rdy, (v ? exp_q[0] : {OW{1'b0}})};
    endfunction

    function automatic logic model_in_ready();
        logic [OW+3:0] e;
        e = model_exp();
        return e[OW];
    endfunction

    task automatic push_word(input logic [IW-1:0] w);
        for (int k = 0; k < R; k++) begin
`ifdef PRIM_FIFO_DOWNSIZER_MSB_FIRST_EN
            exp_q.push_back(w[(R-1-k)*OW +: OW]);
`else
            exp_q.push_back(w[k*OW +: OW]);
`endif
        end
    endtask

    task automatic set_in(input logic v, input logic [IW-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic acc, hs;
        hs  = (exp_q.size() != 0) && out_ready;
        acc = in_valid && model_in_ready();
        if (hs) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (acc) push_word(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_last, busy, in_ready, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {out_valid, out_last, busy, in_ready, out_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        set_in(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (obs_v !== model_exp()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_v, model_exp());
        end
    endtask

    task automatic test_single_word();
        logic [OW-1:0] seen[$];
        for (int i = 0; i < 7; i++) begin
            set_in(i == 0, 32'hA1B2C3D4, 1'b1, 1'b0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL single_word cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            if (out_valid) seen.push_back(out_data);
            tick();
        end
        checks++;
`ifdef PRIM_FIFO_DOWNSIZER_MSB_FIRST_EN
        if (seen.size() != 4 || seen[0] !== 8'hA1 || seen[3] !== 8'hD4) begin
`else
        if (seen.size() != 4 || seen[0] !== 8'hD4 || seen[3] !== 8'hA1) begin
`endif
            failures++;
            $display("FAIL single_word_order got_beats=%0d first=%h", seen.size(), (seen.size() != 0) ? seen[0] : 8'h00);
        end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] words[2];
        int idx;
        int gap;
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        idx = 0;
        gap = 0;
        for (int i = 0; i < 11; i++) begin
            set_in(idx < 2, (idx < 2) ? words[idx] : '0, 1'b1, 1'b0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            if (i >= 1 && i <= 8 && !out_valid) gap++;
            if (in_valid && in_ready) idx++;
            tick();
        end
        checks++;
        if (gap != 0) begin
            failures++;
            $display("FAIL back_to_back_gap got=%0d bubbles exp=0", gap);
        end
    endtask

    task automatic test_stall();
        logic rdy;
        for (int i = 0; i < 12; i++) begin
            rdy = !(i >= 2 && i <= 6);
            set_in(i == 0, 32'h11223344, rdy, 1'b0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            tick();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            set_in(i == 0 || i == 3 || i == 4, (i == 0) ? 32'hA1B2C3D4 : 32'h55667788, 1'b1, i == 3);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_in(1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=000", {out_valid, busy, in_ready});
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_in(i == 1, 32'h9A8B7C6D, 1'b1, 1'b0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 19) == 0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (obs_v !== model_exp()) begin
                failures++;
                $display("FAIL random_drain cyc=%0d got=%h exp=%h", i, obs_v, model_exp());
            end
            tick();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
